// File: rtl/vga_timing_checker_if.sv
// Sync input / recovered-timing output bundle between a sync source and the timing checker.
// Latency: none, plain wires; timing is defined by the checker on the slave side.
// Backpressure: none; the sync pair is a free-running pixel-rate stream.
interface vga_timing_checker_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       locked;
    logic [9:0] h_total_meas;
    logic [9:0] v_total_meas;
    logic [7:0] lock_lost_cnt;

    // Sync source side: drives the syncs, observes the recovered timing.
    modport master (
        output hsync_in, vsync_in,
        input  x, y, de, locked, h_total_meas, v_total_meas, lock_lost_cnt
    );

    // Checker side: consumes the syncs, produces the recovered timing.
    modport slave (
        input  hsync_in, vsync_in,
        output x, y, de, locked, h_total_meas, v_total_meas, lock_lost_cnt
    );
endinterface

// File: rtl/vga_timing_checker.sv
// Recovers position from hsync/vsync edges, measures line/frame/pulse widths, locks and regenerates x/y/de.
// Latency: x/y/de follow the sync sample by 2 clocks; locked follows the deciding edge by 1 clock.
// Backpressure: none; one sync sample per pixel clock, no stall path.
module vga_timing_checker #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_timing_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Counts are compared in 11 bits so that count+1 never wraps.
    localparam logic [10:0] H_TOT11  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT11  = 11'(V_TOTAL);
    localparam logic [10:0] H_OVR11  = 11'(H_TOTAL + 16);
    localparam logic [10:0] V_OVR11  = 11'(V_TOTAL + 4);
    localparam logic [9:0]  H_SYNC10 = 10'(H_SYNC);
    localparam logic [9:0]  V_SYNC10 = 10'(V_SYNC);
    localparam logic [9:0]  H_ACT_LO = 10'(H_ACT_START);
    localparam logic [9:0]  H_ACT_HI = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0]  V_ACT_LO = 10'(V_ACT_START);
    localparam logic [9:0]  V_ACT_HI = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [7:0]  GOOD_TGT = 8'(LOCK_FRAMES);

    // Clamp an incremented 11-bit count back into 10 bits.
    function automatic logic [9:0] sat10(input logic [10:0] v);
        return v[10] ? 10'h3FF : v[9:0];
    endfunction

    // State registers
    logic       hs_prev;
    logic       vs_prev;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       line_err;
    state_t     state;
    logic [7:0] good_cnt;

    // Per-cycle decode
    logic        hs_rise;
    logic        hs_fall;
    logic        vs_rise;
    logic        vs_fall;
    logic [10:0] h_inc;
    logic [10:0] v_inc;
    logic [9:0]  cur_h;
    logic [9:0]  cur_v;
    logic        frame_end;
    logic        frame_ok;
    logic        overrun;
    logic        line_err_next;
    logic [7:0]  good_inc;
    logic        lock_go;
    logic        lock_drop;
    logic        locked_next;
    logic        de_next;
    logic [9:0]  x_next;
    logic [9:0]  y_next;

    // Edge detection, count stepping, width checks and lock decisions for this sample.
    always_comb begin
        hs_rise = bus.hsync_in & ~hs_prev;
        hs_fall = ~bus.hsync_in & hs_prev;
        // vsync edges only count when they line up with an hsync rise
        vs_rise = hs_rise & bus.vsync_in & ~vs_prev;
        vs_fall = hs_rise & ~bus.vsync_in & vs_prev;

        h_inc = {1'b0, h_cnt} + 11'd1;
        v_inc = {1'b0, v_cnt} + 11'd1;
        cur_h = hs_rise ? 10'd0 : sat10(h_inc);
        cur_v = vs_rise ? 10'd0 : sat10(v_inc);

        frame_end = vs_rise;
        frame_ok  = ~line_err & (v_inc == V_TOT11);
        // A stuck-high hsync never re-rises, so it ends here through the horizontal count.
        overrun   = (~hs_rise & (h_inc >= H_OVR11)) |
                    (hs_rise & ~vs_rise & (v_inc >= V_OVR11));

        line_err_next = line_err;
        if (hs_rise && (h_inc != H_TOT11)) begin
            line_err_next = 1'b1;
        end
        if (hs_fall && (cur_h != H_SYNC10)) begin
            line_err_next = 1'b1;
        end
        if (vs_fall && (cur_v != V_SYNC10)) begin
            line_err_next = 1'b1;
        end
        // Each frame starts with a clean slate, even if the closing edge itself was bad.
        if (frame_end) begin
            line_err_next = 1'b0;
        end

        good_inc    = good_cnt + 8'd1;
        lock_go     = (state == CHECK) & ~overrun & frame_end & frame_ok & (good_inc == GOOD_TGT);
        lock_drop   = (state == LOCKED) & (overrun | (frame_end & ~frame_ok));
        locked_next = ((state == LOCKED) & ~lock_drop) | lock_go;

        de_next = locked_next &
                  (h_cnt >= H_ACT_LO) & (h_cnt < H_ACT_HI) &
                  (v_cnt >= V_ACT_LO) & (v_cnt < V_ACT_HI);
        x_next  = de_next ? (h_cnt - H_ACT_LO) : 10'd0;
        y_next  = de_next ? (v_cnt - V_ACT_LO) : 10'd0;
    end

    // Position counters, sync history, error flag and the line/frame measurements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_prev          <= 1'b0;
            vs_prev          <= 1'b0;
            h_cnt            <= 10'd0;
            v_cnt            <= 10'd0;
            line_err         <= 1'b0;
            bus.h_total_meas <= 10'd0;
            bus.v_total_meas <= 10'd0;
        end else begin
            hs_prev  <= bus.hsync_in;
            vs_prev  <= bus.vsync_in;
            h_cnt    <= cur_h;
            line_err <= line_err_next;
            if (hs_rise) begin
                v_cnt            <= cur_v;
                bus.h_total_meas <= sat10(h_inc);
            end
            if (frame_end) begin
                bus.v_total_meas <= sat10(v_inc);
            end
        end
    end

    // Lock state machine: SEARCH waits for a frame boundary, CHECK counts good frames, LOCKED watches for faults.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= SEARCH;
            good_cnt          <= 8'd0;
            bus.locked        <= 1'b0;
            bus.lock_lost_cnt <= 8'd0;
        end else begin
            bus.locked <= locked_next;
            case (state)
                SEARCH: begin
                    // Whatever was measured before the first boundary is partial and ignored.
                    if (frame_end && !overrun) begin
                        state    <= CHECK;
                        good_cnt <= 8'd0;
                    end
                end
                CHECK: begin
                    if (overrun) begin
                        state    <= SEARCH;
                        good_cnt <= 8'd0;
                    end else if (frame_end) begin
                        if (!frame_ok) begin
                            good_cnt <= 8'd0;
                        end else if (lock_go) begin
                            state    <= LOCKED;
                            good_cnt <= 8'd0;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_drop) begin
                        state    <= SEARCH;
                        good_cnt <= 8'd0;
                        if (bus.lock_lost_cnt != 8'hFF) begin
                            bus.lock_lost_cnt <= bus.lock_lost_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= SEARCH;
                    good_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Regenerated pixel position and display enable, gated by lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.de <= 1'b0;
            bus.x  <= 10'd0;
            bus.y  <= 10'd0;
        end else begin
            bus.de <= de_next;
            bus.x  <= x_next;
            bus.y  <= y_next;
        end
    end

endmodule
